// File: rtl/serial_word_deserializer_if.sv
// Serial-in / word-out bundle for the deserializer.
// master drives the serial bits and the consumer's ready; slave is the deserializer itself.
interface serial_word_deserializer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i;
  logic             i_valid;
  logic             i_start;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic             o_ready;
  logic             o_overrun;
  logic             o_abort;

  modport master (
    output i, i_valid, i_start, o_ready,
    input  o, o_valid, o_overrun, o_abort
  );

  modport slave (
    input  i, i_valid, i_start, o_ready,
    output o, o_valid, o_overrun, o_abort
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Assembles a start-framed 1-bit stream into WIDTH-bit words and presents each completed
// word through a single valid/ready holding register. A word completing while the holding
// register is still occupied is dropped (overrun); a new start mid-word discards the
// partial word (abort).
module serial_word_deserializer #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  serial_word_deserializer_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic {StIdle, StCollect} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] sh_first;
  logic [WIDTH-1:0] o_q;
  logic             o_valid_q;
  logic             overrun_q;
  logic             abort_q;

  // Shift-register next values: continuing a word, or starting a fresh one from zero.
  always_comb begin
    sh_d     = '0;
    sh_first = '0;
    if (LSB_FIRST) begin
      sh_d     = {bus.i, sh_q[WIDTH-1:1]};
      sh_first = {bus.i, {(WIDTH-1){1'b0}}};
    end else begin
      sh_d     = {sh_q[WIDTH-2:0], bus.i};
      sh_first = {{(WIDTH-1){1'b0}}, bus.i};
    end
  end

  // Framing FSM, bit counter, holding register and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sh_q      <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
      // Consume first; a completion below may refill the register on the same edge.
      if (o_valid_q && bus.o_ready) begin
        o_valid_q <= 1'b0;
      end
      if (bus.i_valid) begin
        if (bus.i_start) begin
          // In COLLECT cnt is never zero, so any start there discards a partial word,
          // including on what would have been the completing bit.
          if (state_q == StCollect) begin
            abort_q <= 1'b1;
          end
          sh_q    <= sh_first;
          cnt_q   <= OneCnt;
          state_q <= StCollect;
        end else if (state_q == StCollect) begin
          sh_q <= sh_d;
          if (cnt_q == LastCnt) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (!o_valid_q || bus.o_ready) begin
              o_q       <= sh_d;
              o_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + OneCnt;
          end
        end
      end
    end
  end

  assign bus.o         = o_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_overrun = overrun_q;
  assign bus.o_abort   = abort_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: an LSB-first and an MSB-first instance share one
// serial stream; a bit-queue reference model predicts both every cycle.
module tb_serial_word_deserializer;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  logic s_i, s_iv, s_is, s_rdy;

  int checks   = 0;
  int failures = 0;
  int ab_seen  = 0;
  int ov_seen  = 0;
  int words_l  = 0;

  serial_word_deserializer_if #(.WIDTH(W)) bus_l ();
  serial_word_deserializer_if #(.WIDTH(W)) bus_m ();

  assign bus_l.i       = s_i;
  assign bus_l.i_valid = s_iv;
  assign bus_l.i_start = s_is;
  assign bus_l.o_ready = s_rdy;
  assign bus_m.i       = s_i;
  assign bus_m.i_valid = s_iv;
  assign bus_m.i_start = s_is;
  assign bus_m.o_ready = s_rdy;

  serial_word_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  serial_word_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.slave)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the current frame in arrival order.
  bit           q[$];
  logic [W-1:0] m_o_l = '0;
  logic [W-1:0] m_o_m = '0;
  bit           m_v   = 1'b0;
  bit           m_ov  = 1'b0;
  bit           m_ab  = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model(input bit r, input bit b, input bit iv, input bit is, input bit rdy);
    bit           comp = 1'b0;
    logic [W-1:0] wl = '0;
    logic [W-1:0] wm = '0;
    m_ov = 1'b0;
    m_ab = 1'b0;
    if (r) begin
      q.delete();
      m_o_l = '0;
      m_o_m = '0;
      m_v   = 1'b0;
    end else begin
      if (iv) begin
        if (is) begin
          if (q.size() != 0) m_ab = 1'b1;
          q.delete();
          q.push_back(b);
        end else if (q.size() != 0) begin
          q.push_back(b);
          if (q.size() == W) begin
            comp = 1'b1;
            for (int k = 0; k < W; k++) begin
              wl[k]       = q[k];
              wm[W-1-k]   = q[k];
            end
            q.delete();
          end
        end
      end
      if (comp) begin
        if (!m_v || rdy) begin
          m_o_l = wl;
          m_o_m = wm;
          m_v   = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_v && rdy) begin
        m_v = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit r, input bit b, input bit iv, input bit is, input bit rdy);
    rst   = r;
    s_i   = b;
    s_iv  = iv;
    s_is  = is;
    s_rdy = rdy;
    @(posedge clk);
    model(r, b, iv, is, rdy);
    #1;
    chk("o_valid_lsb", 64'(bus_l.o_valid), 64'(m_v));
    chk("o_valid_msb", 64'(bus_m.o_valid), 64'(m_v));
    chk("o_lsb", 64'(bus_l.o), 64'(m_o_l));
    chk("o_msb", 64'(bus_m.o), 64'(m_o_m));
    chk("overrun_lsb", 64'(bus_l.o_overrun), 64'(m_ov));
    chk("overrun_msb", 64'(bus_m.o_overrun), 64'(m_ov));
    chk("abort_lsb", 64'(bus_l.o_abort), 64'(m_ab));
    chk("abort_msb", 64'(bus_m.o_abort), 64'(m_ab));
    if (bus_l.o_abort) ab_seen++;
    if (bus_l.o_overrun) ov_seen++;
    if (bus_l.o_valid && m_v && r == 1'b0 && iv && q.size() == 0) words_l++;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit msb, input bit rdy, input bit rdy_last);
    for (int k = 0; k < W; k++) begin
      step(1'b0, msb ? w[W-1-k] : w[k], 1'b1, k == 0, (k == W - 1) ? rdy_last : rdy);
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    bit           msb_first;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_m;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int ab0;
    int ov0;

    vecs[0] = '{word: 32'hA5A50F0F, msb_first: 1'b0, exp_l: 32'hA5A50F0F, exp_m: 32'hF0F0A5A5};
    vecs[1] = '{word: 32'h80000001, msb_first: 1'b1, exp_l: 32'h80000001, exp_m: 32'h80000001};
    vecs[2] = '{word: 32'h12345678, msb_first: 1'b0, exp_l: 32'h12345678, exp_m: 32'h1E6A2C48};
    vecs[3] = '{word: 32'h0000FFFF, msb_first: 1'b0, exp_l: 32'h0000FFFF, exp_m: 32'hFFFF0000};

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_o", 64'(bus_l.o), 64'd0);
    chk("reset_valid", 64'(bus_l.o_valid), 64'd0);

    // Table: each word, o_ready high, valid for exactly one cycle after the last bit.
    for (int n = 0; n < 4; n++) begin
      send_word(vecs[n].word, vecs[n].msb_first, 1'b1, 1'b1);
      chk("tbl_valid", 64'(bus_l.o_valid), 64'd1);
      chk("tbl_o_lsb", 64'(bus_l.o), 64'(vecs[n].exp_l));
      chk("tbl_o_msb", 64'(bus_m.o), 64'(vecs[n].exp_m));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("tbl_valid_drop", 64'(bus_l.o_valid), 64'd0);
    end

    // Overrun: second word dropped while the first is held.
    ov0 = ov_seen;
    send_word(32'h11111111, 1'b0, 1'b0, 1'b0);
    send_word(32'h22222222, 1'b0, 1'b0, 1'b0);
    chk("ovr_pulse", 64'(bus_l.o_overrun), 64'd1);
    chk("ovr_held", 64'(bus_l.o), 64'h11111111);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_pulse_once", 64'(ov_seen - ov0), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_consumed", 64'(bus_l.o_valid), 64'd0);

    // Simultaneous consume and complete.
    ov0 = ov_seen;
    send_word(32'h11111111, 1'b0, 1'b0, 1'b0);
    send_word(32'h33333333, 1'b0, 1'b0, 1'b1);
    chk("sim_o", 64'(bus_l.o), 64'h33333333);
    chk("sim_valid", 64'(bus_l.o_valid), 64'd1);
    chk("sim_no_ovr", 64'(ov_seen - ov0), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort: 10 bits, then a new start with a full word.
    ab0 = ab_seen;
    for (int k = 0; k < 10; k++) step(1'b0, k[0], 1'b1, k == 0, 1'b1);
    send_word(32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    chk("abort_o", 64'(bus_l.o), 64'hDEADBEEF);
    chk("abort_once", 64'(ab_seen - ab0), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start on the completing bit: abort, nothing written, new word follows.
    ab0 = ab_seen;
    for (int k = 0; k < W - 1; k++) step(1'b0, 1'b1, 1'b1, k == 0, 1'b1);
    send_word(32'h0F0F1234, 1'b0, 1'b1, 1'b1);
    chk("late_start_o", 64'(bus_l.o), 64'h0F0F1234);
    chk("late_start_abort", 64'(ab_seen - ab0), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word with a pending word, then idle bits without start.
    send_word(32'h55AA55AA, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b1, k == 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_o", 64'(bus_l.o), 64'd0);
    chk("rst_valid", 64'(bus_l.o_valid), 64'd0);
    ab0 = ab_seen;
    ov0 = ov_seen;
    for (int k = 0; k < 40; k++) step(1'b0, k[1], 1'b1, 1'b0, 1'b0);
    chk("idle_no_word", 64'(bus_l.o_valid), 64'd0);
    chk("idle_no_pulses", 64'((ab_seen - ab0) + (ov_seen - ov0)), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 599) == 0, 1'($urandom), $urandom_range(0, 9) < 8,
           $urandom_range(0, 44) == 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Receives a 1-bit serial stream, framed by a start strobe, and assembles it into WIDTH-bit parallel words. Each completed word is presented on a valid/ready output port backed by a single holding register. This is the receive-side counterpart of the parallel-to-serial path that drives a wide bus (i1[31:0]) out onto a single-bit output (o). It sits between a serial link input and any 32-bit consumer in the design.

## Interface
- WIDTH, 32: word width in bits; legal range 2..64.
- LSB_FIRST, 1: 1 = the first serial bit is bit 0; 0 = the first serial bit is bit WIDTH-1.
- clk  input  1  single clock; all logic samples on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i  input  1  serial data bit; sampled only when i_valid=1.
- i_valid  input  1  bit strobe; one bit is accepted per cycle where i_valid=1.
- i_start  input  1  frame start; meaningful only when i_valid=1; marks i as the first bit of a word.
- o  output  WIDTH  assembled word; stable while o_valid=1.
- o_valid  output  1  o holds an unconsumed word.
- o_ready  input  1  consumer accepts o; a transfer happens on an edge where o_valid & o_ready.
- o_overrun  output  1  one-cycle pulse: a completed word was dropped.
- o_abort  output  1  one-cycle pulse: a partial word was discarded by a new i_start.

## Operation
- Registers:
  - shift register sh[WIDTH-1:0].
  - bit counter cnt, ceil(log2(WIDTH+1)) bits.
  - state: IDLE or COLLECT.
  - output register o plus the o_valid flag.
- IDLE:
  - Bits with i_valid=1 and i_start=0 are ignored.
  - i_valid & i_start: sh takes the first bit, cnt=1, go to COLLECT.
- COLLECT:
  - Each i_valid=1 shifts i into sh and increments cnt.
  - LSB_FIRST=1: sh <= {i, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], i}.
- Word completion, on the edge that accepts bit number WIDTH:
  - If the holding register is free (o_valid=0, or o_valid & o_ready on the same edge): o <= the assembled word, o_valid <= 1.
  - Otherwise: the new word is dropped, o keeps the old word, and o_overrun pulses.
  - In both cases cnt is cleared and the state returns to IDLE.
- i_start with i_valid while in COLLECT and cnt != 0:
  - The partial word is discarded and o_abort pulses.
  - The current bit starts a new word: cnt=1, stay in COLLECT.
- i_start on the completing bit (cnt == WIDTH-1): the start wins. The partial word is aborted, nothing is written to o, and a new word starts.
- Output consumption: o_valid & o_ready with no new word completing clears o_valid. o is not cleared; it keeps its last value.
- Simultaneous consume and complete on one edge: o takes the new word and o_valid stays 1. No overrun.
- Counter arithmetic: cnt never exceeds WIDTH-1 while in COLLECT; no wrap-around.

## Timing
- Reset values: o=0, o_valid=0, o_overrun=0, o_abort=0, state=IDLE, cnt=0, sh=0.
- rst asserted mid-word: the partial word and any pending o are lost. No overrun or abort pulse is generated.
- Latency: o_valid rises one cycle after the edge that samples the final bit. The first bit to o_valid takes at least WIDTH cycles.
- Throughput: with o_ready tied to 1, words may arrive back to back (one bit per cycle) without loss.
- Pulse timing: o_overrun and o_abort are registered and high for exactly one cycle, in the cycle after the triggering edge.
- Output stability: o and o_valid change only on a consume or a completion edge. o is stable while o_valid=1 and o_ready=0.

## Test plan
- Basic word: WIDTH=32, LSB_FIRST=1, o_ready=1. Send 0xA5A50F0F LSB first with i_start on bit 0. Required: o=0xA5A50F0F and o_valid=1 for exactly one cycle, one cycle after bit 31.
- MSB first: LSB_FIRST=0. Send 0x80000001 with the MSB first. Required: o=0x80000001.
- Overrun: o_ready=0. Send 0x11111111 then 0x22222222 back to back. Required: o=0x11111111 is held, and o_overrun pulses once after the 64th bit. Then o_ready=1 consumes it, and o_valid falls.
- Simultaneous consume and complete: hold word 0x11111111. Assert o_ready on the same edge as the last bit of 0x33333333. Required: o=0x33333333, o_valid stays 1, no overrun.
- Abort: send 10 bits, then i_start plus a full 0xDEADBEEF. Required: o_abort pulses once, and only 0xDEADBEEF is output.
- Reset and idle bits: reset after 20 bits, then send i_valid bits without i_start. Required: all outputs at reset values; no word is produced.
